// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run sequencer.
// Optional PC trace outputs on the top are enabled by CPU_RUN_CTRL_PC_TRACE_EN.
package cpu_ctrl_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    localparam int DEF_WARMUP_CYCLES    = 3;
    localparam int DEF_MAX_CYCLES       = 240;
    localparam int DEF_SELF_LOOP_CYCLES = 4;
    localparam int DEF_DRAIN_CYCLES     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } run_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_pc_loop_detect.sv
// Branch-to-self detector: counts consecutive enabled cycles with an unchanged PC.
// loop_hit is combinational and reflects the count after this cycle's update.
module pc_loop_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int SELF_LOOP_CYCLES = DEF_SELF_LOOP_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    output logic            loop_hit
);

    localparam int CW = $clog2(SELF_LOOP_CYCLES) + 1;

    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            prev_vld_q, prev_vld_d;
    logic [CW-1:0]   match_cnt_q, match_cnt_d;
    logic            pc_same;

    // prev_vld keeps the first enabled cycle from matching a cleared register
    always_comb begin
        pc_same     = prev_vld_q && (pc == prev_pc_q);
        prev_pc_d   = prev_pc_q;
        prev_vld_d  = prev_vld_q;
        match_cnt_d = match_cnt_q;
        if (clr) begin
            prev_pc_d   = '0;
            prev_vld_d  = 1'b0;
            match_cnt_d = '0;
        end else if (en) begin
            prev_pc_d  = pc;
            prev_vld_d = 1'b1;
            if (!pc_same)
                match_cnt_d = '0;
            else if (match_cnt_q != '1)
                match_cnt_d = match_cnt_q + CW'(1);
        end
        loop_hit = en && !clr && (match_cnt_d == CW'(SELF_LOOP_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pc_q   <= '0;
            prev_vld_q  <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            prev_vld_q  <= prev_vld_d;
            match_cnt_q <= match_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the CPU: load entry PC, warm up, run until halt/self-loop/budget, drain, report.
// Define CPU_RUN_CTRL_PC_TRACE_EN to add the last_pc / pc_changes trace outputs.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES    = DEF_WARMUP_CYCLES,
    parameter int MAX_CYCLES       = DEF_MAX_CYCLES,
    parameter int SELF_LOOP_CYCLES = DEF_SELF_LOOP_CYCLES,
    parameter int DRAIN_CYCLES     = DEF_DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [PC_W-1:0]   pc_cur,
    input  logic              halt_insn,
    output logic              pc_ld,
    output logic [PC_W-1:0]   pc_data,
    output logic              clockthing,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
    ,
    output logic [PC_W-1:0]   last_pc,
    output logic [15:0]       pc_changes
`endif
);

    localparam logic [CNT_W-1:0] WARM_LOAD   = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [PC_W-1:0]  pc_data_q, pc_data_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             timeout_q, timeout_d;
    logic             pc_ld_q, pc_ld_d;
    logic             clockthing_q, clockthing_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             loop_hit;

    pc_loop_detect #(
        .SELF_LOOP_CYCLES (SELF_LOOP_CYCLES)
    ) u_loop (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q != ST_RUN),
        .en       (state_q == ST_RUN),
        .pc       (pc_cur),
        .loop_hit (loop_hit)
    );

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        pc_data_d     = pc_data_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    pc_data_d     = start_pc;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_WARMUP;
                tmr_d   = WARM_LOAD;
            end
            ST_WARMUP: begin
                if (tmr_q == '0) state_d = ST_RUN;
                else             tmr_d   = tmr_q - CNT_W'(1);
            end
            ST_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                // an end condition beats budget exhaustion in the same cycle
                if (halt_insn || loop_hit) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        tmr_d   = DRAIN_LOAD;
                    end
                end else if (cycle_count_q == BUDGET_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (tmr_q == '0) state_d = ST_DONE;
                else             tmr_d   = tmr_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        pc_ld_d      = (state_d == ST_LOAD);
        clockthing_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_WARMUP) ||
                       (state_d == ST_RUN)  || (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            pc_data_q     <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            pc_ld_q       <= 1'b0;
            clockthing_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pc_data_q     <= pc_data_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            pc_ld_q       <= pc_ld_d;
            clockthing_q  <= clockthing_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pc_ld       = pc_ld_q;
    assign pc_data     = pc_data_q;
    assign clockthing  = clockthing_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

`ifdef CPU_RUN_CTRL_PC_TRACE_EN
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [15:0]     pc_changes_q, pc_changes_d;

    // last_pc is zero on RUN entry, so it doubles as the previous-PC reference
    always_comb begin
        last_pc_d    = last_pc_q;
        pc_changes_d = pc_changes_q;
        if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
            last_pc_d    = '0;
            pc_changes_d = '0;
        end else if (state_q == ST_RUN) begin
            last_pc_d = pc_cur;
            if (pc_cur != last_pc_q && pc_changes_q != '1)
                pc_changes_d = pc_changes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q    <= '0;
            pc_changes_q <= '0;
        end else begin
            last_pc_q    <= last_pc_d;
            pc_changes_q <= pc_changes_d;
        end
    end

    assign last_pc    = last_pc_q;
    assign pc_changes = pc_changes_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances (defaults, MAX_CYCLES=50, DRAIN_CYCLES=0) on shared stimulus.
// Expected run results are queued at start and popped when the selected instance reports done.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_pc;
    logic [31:0] pc_cur;
    logic        halt_insn;

    logic [2:0]  pc_ld_w, clk_w, busy_w, done_w, to_w;
    logic [31:0] pc_data_w [3];
    logic [31:0] cc_w      [3];
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
    logic [31:0] last_pc_w [3];
    logic [15:0] pc_chg_w  [3];
`endif

    cpu_run_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc_cur(pc_cur),
        .halt_insn(halt_insn), .pc_ld(pc_ld_w[0]), .pc_data(pc_data_w[0]),
        .clockthing(clk_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .timeout(to_w[0]), .cycle_count(cc_w[0])
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
        , .last_pc(last_pc_w[0]), .pc_changes(pc_chg_w[0])
`endif
    );

    cpu_run_ctrl #(.MAX_CYCLES(50)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc_cur(pc_cur),
        .halt_insn(halt_insn), .pc_ld(pc_ld_w[1]), .pc_data(pc_data_w[1]),
        .clockthing(clk_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .timeout(to_w[1]), .cycle_count(cc_w[1])
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
        , .last_pc(last_pc_w[1]), .pc_changes(pc_chg_w[1])
`endif
    );

    cpu_run_ctrl #(.DRAIN_CYCLES(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .pc_cur(pc_cur),
        .halt_insn(halt_insn), .pc_ld(pc_ld_w[2]), .pc_data(pc_data_w[2]),
        .clockthing(clk_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .timeout(to_w[2]), .cycle_count(cc_w[2])
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
        , .last_pc(last_pc_w[2]), .pc_changes(pc_chg_w[2])
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cc;
        int en;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   sel   = 0;

    function automatic logic [31:0] pc_of(input int r, input int stick_at);
        if (stick_at > 0 && r >= stick_at) return 32'h40;
        return 32'h100 + 32'(4 * r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; halt_insn = 1'b0; pc_cur = '0; start_pc = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic accept(input logic [31:0] pc);
        start = 1'b1; start_pc = pc;
        step();
        start = 1'b0;
    endtask

    // Drives pc_cur/halt/start per RUN-or-DRAIN cycle index r until done or budget expiry.
    task automatic monitor(input int halt_at, input int stick_at, input int start_at,
                           output int enabled, output bit fin);
        int r;
        r = 0; enabled = 0; fin = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done_w[sel]) begin
                fin = 1'b1;
                break;
            end
            if (clk_w[sel]) begin
                r++;
                enabled++;
            end
            pc_cur    = pc_of(r, stick_at);
            halt_insn = clk_w[sel] && (r == halt_at);
            start     = clk_w[sel] && (r == start_at);
            start_pc  = 32'hDEAD0000;
            step();
        end
        halt_insn = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({pc_ld_w[i], clk_w[i], busy_w[i], done_w[i], to_w[i]} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_flags[%0d]: got %b expected 00000", i,
                         {pc_ld_w[i], clk_w[i], busy_w[i], done_w[i], to_w[i]});
            end
            n_cmp++;
            if (pc_data_w[i] !== 32'h0) begin
                n_err++; $display("FAIL reset_pc_data[%0d]: got %h expected 0", i, pc_data_w[i]);
            end
            n_cmp++;
            if (cc_w[i] !== 32'h0) begin
                n_err++; $display("FAIL reset_cycle_count[%0d]: got %0d expected 0", i, cc_w[i]);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e; int en; bit fin;
        do_reset(); sel = 0;
        sb.push_back('{cc: 10, en: 14, to: 1'b0});
        accept(32'h00400020);
        n_cmp++;
        if ({pc_ld_w[0], busy_w[0], clk_w[0]} !== 3'b110) begin
            n_err++; $display("FAIL load_cycle: got ld/busy/clk=%b expected 110", {pc_ld_w[0], busy_w[0], clk_w[0]});
        end
        n_cmp++;
        if (pc_data_w[0] !== 32'h00400020) begin
            n_err++; $display("FAIL load_pc_data: got %h expected 00400020", pc_data_w[0]);
        end
        step();
        n_cmp++;
        if (pc_ld_w[0] !== 1'b0 || pc_data_w[0] !== 32'h00400020) begin
            n_err++; $display("FAIL load_one_cycle: got ld=%b data=%h expected 0/00400020", pc_ld_w[0], pc_data_w[0]);
        end
        step(); step();
        n_cmp++;
        if (clk_w[0] !== 1'b0) begin
            n_err++; $display("FAIL warmup_last: got clockthing=%b expected 0", clk_w[0]);
        end
        step();
        n_cmp++;
        if (clk_w[0] !== 1'b1) begin
            n_err++; $display("FAIL run_start: got clockthing=%b expected 1", clk_w[0]);
        end
        monitor(10, 0, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b expected 1", fin); end
        n_cmp++;
        if (cc_w[0] !== 32'(e.cc)) begin n_err++; $display("FAIL basic_cycle_count: got %0d expected %0d", cc_w[0], e.cc); end
        n_cmp++;
        if (en !== e.en) begin n_err++; $display("FAIL basic_enabled: got %0d expected %0d", en, e.en); end
        n_cmp++;
        if ({to_w[0], clk_w[0], busy_w[0]} !== {e.to, 2'b00}) begin
            n_err++; $display("FAIL basic_final: got to/clk/busy=%b expected %b", {to_w[0], clk_w[0], busy_w[0]}, {e.to, 2'b00});
        end
    endtask

    task automatic test_self_loop();
        exp_t e; int en; bit fin;
        do_reset(); sel = 0;
        sb.push_back('{cc: 23, en: 27, to: 1'b0});
        accept(32'h00001000);
        monitor(0, 20, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1) begin n_err++; $display("FAIL loop_done: got %b expected 1", fin); end
        n_cmp++;
        if (cc_w[0] !== 32'(e.cc)) begin n_err++; $display("FAIL loop_cycle_count: got %0d expected %0d", cc_w[0], e.cc); end
        n_cmp++;
        if (en !== e.en) begin n_err++; $display("FAIL loop_enabled: got %0d expected %0d", en, e.en); end
`ifdef CPU_RUN_CTRL_PC_TRACE_EN
        begin
            logic [31:0] prev, last; int chg;
            prev = '0; last = '0; chg = 0;
            for (int r = 1; r <= e.cc; r++) begin
                if (pc_of(r, 20) != prev) chg++;
                prev = pc_of(r, 20);
                last = prev;
            end
            n_cmp++;
            if (last_pc_w[0] !== last) begin n_err++; $display("FAIL trace_last_pc: got %h expected %h", last_pc_w[0], last); end
            n_cmp++;
            if (pc_chg_w[0] !== 16'(chg)) begin n_err++; $display("FAIL trace_pc_changes: got %0d expected %0d", pc_chg_w[0], chg); end
        end
`endif
    endtask

    task automatic test_timeout();
        exp_t e; int en; bit fin;
        do_reset(); sel = 1;
        sb.push_back('{cc: 50, en: 50, to: 1'b1});
        accept(32'h00002000);
        monitor(0, 0, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1) begin n_err++; $display("FAIL timeout_done: got %b expected 1", fin); end
        n_cmp++;
        if (cc_w[1] !== 32'(e.cc)) begin n_err++; $display("FAIL timeout_cycle_count: got %0d expected %0d", cc_w[1], e.cc); end
        n_cmp++;
        if (en !== e.en) begin n_err++; $display("FAIL timeout_no_drain: got %0d expected %0d", en, e.en); end
        n_cmp++;
        if (to_w[1] !== e.to) begin n_err++; $display("FAIL timeout_flag: got %b expected %b", to_w[1], e.to); end
    endtask

    task automatic test_simultaneous();
        exp_t e; int en; bit fin;
        do_reset(); sel = 1;
        sb.push_back('{cc: 50, en: 54, to: 1'b0});
        accept(32'h00002000);
        monitor(50, 0, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1) begin n_err++; $display("FAIL simul_done: got %b expected 1", fin); end
        n_cmp++;
        if (en !== e.en) begin n_err++; $display("FAIL simul_drain: got %0d expected %0d", en, e.en); end
        n_cmp++;
        if (to_w[1] !== e.to) begin n_err++; $display("FAIL simul_timeout: got %b expected %b", to_w[1], e.to); end
    endtask

    task automatic test_start_in_run();
        exp_t e; int en; bit fin;
        do_reset(); sel = 0;
        sb.push_back('{cc: 10, en: 14, to: 1'b0});
        accept(32'h00003000);
        monitor(10, 0, 5, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1 || en !== e.en) begin
            n_err++; $display("FAIL start_in_run_enabled: got fin=%b en=%0d expected 1/%0d", fin, en, e.en);
        end
        n_cmp++;
        if (cc_w[0] !== 32'(e.cc) || pc_data_w[0] !== 32'h00003000) begin
            n_err++; $display("FAIL start_in_run_state: got cc=%0d pc=%h expected %0d/00003000", cc_w[0], pc_data_w[0], e.cc);
        end
    endtask

    task automatic test_start_in_done();
        exp_t e; int en; bit fin;
        sel = 0;
        sb.push_back('{cc: 7, en: 11, to: 1'b0});
        accept(32'h00004000);
        n_cmp++;
        if ({done_w[0], pc_ld_w[0]} !== 2'b01 || cc_w[0] !== 32'h0) begin
            n_err++; $display("FAIL rerun_accept: got done/ld=%b cc=%0d expected 01/0", {done_w[0], pc_ld_w[0]}, cc_w[0]);
        end
        n_cmp++;
        if (pc_data_w[0] !== 32'h00004000) begin n_err++; $display("FAIL rerun_pc_data: got %h expected 00004000", pc_data_w[0]); end
        monitor(7, 0, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1 || cc_w[0] !== 32'(e.cc) || en !== e.en) begin
            n_err++; $display("FAIL rerun_result: got fin=%b cc=%0d en=%0d expected 1/%0d/%0d", fin, cc_w[0], en, e.cc, e.en);
        end
    endtask

    task automatic test_drain_zero();
        exp_t e; int en; bit fin;
        do_reset(); sel = 2;
        sb.push_back('{cc: 10, en: 10, to: 1'b0});
        accept(32'h00005000);
        monitor(10, 0, 0, en, fin);
        e = sb.pop_front();
        n_cmp++;
        if (fin !== 1'b1 || clk_w[2] !== 1'b0) begin
            n_err++; $display("FAIL drain0_done: got fin=%b clk=%b expected 1/0", fin, clk_w[2]);
        end
        n_cmp++;
        if (en !== e.en || cc_w[2] !== 32'(e.cc)) begin
            n_err++; $display("FAIL drain0_counts: got en=%0d cc=%0d expected %0d/%0d", en, cc_w[2], e.en, e.cc);
        end
    endtask

    task automatic test_rst_in_drain();
        int r; bit hit;
        do_reset(); sel = 0;
        accept(32'h00006000);
        r = 0; hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (clk_w[0]) r++;
            if (r == 7) begin
                hit = 1'b1;
                break;
            end
            halt_insn = clk_w[0] && (r == 5);
            step();
        end
        halt_insn = 1'b0;
        n_cmp++;
        if (hit !== 1'b1 || clk_w[0] !== 1'b1) begin
            n_err++; $display("FAIL rst_drain_reach: got hit=%b clk=%b expected 1/1", hit, clk_w[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({pc_ld_w[0], clk_w[0], busy_w[0], done_w[0], to_w[0]} !== 5'b0 ||
            pc_data_w[0] !== 32'h0 || cc_w[0] !== 32'h0) begin
            n_err++; $display("FAIL rst_drain_outputs: got flags=%b pc=%h cc=%0d expected 0/0/0",
                              {pc_ld_w[0], clk_w[0], busy_w[0], done_w[0], to_w[0]}, pc_data_w[0], cc_w[0]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_self_loop();
        test_timeout();
        test_simultaneous();
        test_start_in_run();
        test_start_in_done();
        test_drain_zero();
        test_rst_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
